// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encryptor and its benches.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    KSA_RI,
    KSA_WI,
    KSA_RJ,
    KSA_WJ,
    KSA_WR_I,
    KSA_WR_J,
    LEN,
    PRGA_RI,
    PRGA_WI,
    PRGA_RJ,
    PRGA_WJ,
    PRGA_WR_I,
    PRGA_WR_J,
    PRGA_RP,
    PRGA_WP,
    DONE
  } state_t;

  // Printable ASCII range, used by benches to build plaintext images.
  localparam byte_t PT_PRINTABLE_LO = 8'h20;
  localparam byte_t PT_PRINTABLE_HI = 8'h7E;

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed pt memory in, length-prefixed ct memory out,
// using an external single-port S memory with one cycle of read latency.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | rdy=1, waiting for en; key captured on accept
// INIT       | write S[i]=i, one entry per cycle
// KSA_RI     | S[i] address on the bus
// KSA_WI     | S[i] arrives; compute j=j+S[i]+keybyte, address S[j]
// KSA_RJ     | S[j] address on the bus
// KSA_WJ     | S[j] arrives; start swap with write S[i]=S[j]
// KSA_WR_I   | write S[i] in flight; next write S[j]=old S[i]
// KSA_WR_J   | write S[j] in flight; advance i or leave for LEN
// LEN        | pt[0] valid (pt_addr held at 0 since accept); write ct[0]
// PRGA_RI    | S[i] address on the bus (i already incremented)
// PRGA_WI    | S[i] arrives; j=j+S[i], address S[j]
// PRGA_RJ    | S[j] address on the bus
// PRGA_WJ    | S[j] arrives; start swap
// PRGA_WR_I  | write S[i] in flight
// PRGA_WR_J  | write S[j] in flight; address S[S[i]+S[j]]
// PRGA_RP    | pad address on the bus
// PRGA_WP    | pad arrives; issue ct[k]=pt[k]^pad, advance k or finish
// DONE       | final ct write in flight; return to IDLE
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEYLEN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                rdy,
  input  logic [8*KEYLEN-1:0] key,
  output logic [7:0]          s_addr,
  input  logic [7:0]          s_rddata,
  output logic [7:0]          s_wrdata,
  output logic                s_wren,
  output logic [7:0]          pt_addr,
  input  logic [7:0]          pt_rddata,
  output logic [7:0]          ct_addr,
  output logic [7:0]          ct_wrdata,
  output logic                ct_wren
);

  state_t              state;
  byte_t               i, j, k, len, si, sj;
  logic [8*KEYLEN-1:0] key_r;
  byte_t               key_byte;
  byte_t               j_ksa, j_prga;

  // Select key byte (i mod KEYLEN); byte 0 is the most significant byte.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEYLEN; b++) begin
      if ((int'(i) % KEYLEN) == b) key_byte = key_r[8*(KEYLEN-b)-1 -: 8];
    end
  end

  assign j_ksa  = j + s_rddata + key_byte;
  assign j_prga = j + s_rddata;

  // Sequencer with registered memory-port outputs; write enables default low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
      si        <= '0;
      sj        <= '0;
      key_r     <= '0;
    end else begin
      s_wren  <= 1'b0;
      ct_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_r    <= key;
            rdy      <= 1'b0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            s_addr   <= '0;
            s_wrdata <= '0;
            s_wren   <= 1'b1;
            pt_addr  <= '0;
            state    <= INIT;
          end
        end
        INIT: begin
          if (i == 8'hFF) begin
            i      <= '0;
            j      <= '0;
            s_addr <= '0;
            state  <= KSA_RI;
          end else begin
            i        <= i + 8'd1;
            s_addr   <= i + 8'd1;
            s_wrdata <= i + 8'd1;
            s_wren   <= 1'b1;
          end
        end
        KSA_RI: state <= KSA_WI;
        KSA_WI: begin
          si     <= s_rddata;
          j      <= j_ksa;
          s_addr <= j_ksa;
          state  <= KSA_RJ;
        end
        KSA_RJ: state <= KSA_WJ;
        KSA_WJ: begin
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= KSA_WR_I;
        end
        KSA_WR_I: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= KSA_WR_J;
        end
        KSA_WR_J: begin
          if (i == 8'hFF) begin
            i     <= '0;
            j     <= '0;
            state <= LEN;
          end else begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            state  <= KSA_RI;
          end
        end
        LEN: begin
          len       <= pt_rddata;
          ct_addr   <= '0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          pt_addr   <= 8'd1;
          if (pt_rddata <= 8'd1) begin
            state <= DONE;
          end else begin
            i      <= 8'd1;
            k      <= 8'd1;
            s_addr <= 8'd1;
            state  <= PRGA_RI;
          end
        end
        PRGA_RI: state <= PRGA_WI;
        PRGA_WI: begin
          si     <= s_rddata;
          j      <= j_prga;
          s_addr <= j_prga;
          state  <= PRGA_RJ;
        end
        PRGA_RJ: state <= PRGA_WJ;
        PRGA_WJ: begin
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= PRGA_WR_I;
        end
        PRGA_WR_I: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= PRGA_WR_J;
        end
        PRGA_WR_J: begin
          // Post-swap S[i]+S[j] equals pre-swap si+sj, so the held copies suffice.
          s_addr <= si + sj;
          state  <= PRGA_RP;
        end
        PRGA_RP: state <= PRGA_WP;
        PRGA_WP: begin
          ct_addr   <= k;
          ct_wrdata <= pt_rddata ^ s_rddata;
          ct_wren   <= 1'b1;
          if (k == len - 8'd1) begin
            state <= DONE;
          end else begin
            k       <= k + 8'd1;
            pt_addr <= k + 8'd1;
            i       <= i + 8'd1;
            s_addr  <= i + 8'd1;
            state   <= PRGA_RI;
          end
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: memory models around the DUT and a plain ARC4
// reference computed directly from the algorithm on integer arrays.
module tb_arc4_encrypt;
  import arc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = '0;
  logic        rdy, s_wren, ct_wren;
  logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;

  always #5 clk = ~clk;

  arc4_encrypt #(.KEYLEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem[256];
  logic [7:0] ct_mem[256];
  int ct_pulses, ct_oob, cur_len;
  int checks = 0;
  int errors = 0;
  int ref_ksa[256], ref_s[256], ref_ct[256];
  byte_t kv_ct[10] = '{8'h0A, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  // S and pt memories: registered read data, one cycle latency
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
  end

  // ct memory with pulse and out-of-range write accounting
  always @(posedge clk) begin
    if (ct_wren) begin
      ct_mem[ct_addr] = ct_wrdata;
      ct_pulses++;
      if (cur_len == 0 ? (ct_addr != 8'd0) : (int'(ct_addr) >= cur_len)) ct_oob++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int kbyte(input logic [23:0] k, input int b);
    return int'((k >> (8 * (2 - b))) & 24'hFF);
  endfunction

  task automatic model_run(input logic [23:0] k);
    int s[256];
    int j, t, l, ii;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kbyte(k, n % 3)) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    ref_ksa = s;
    l = int'(pt_mem[0]);
    ref_ct[0] = l;
    ii = 0;
    j = 0;
    for (int n = 1; n < l; n++) begin
      ii = (ii + 1) % 256;
      j = (j + s[ii]) % 256;
      t = s[ii]; s[ii] = s[j]; s[j] = t;
      ref_ct[n] = int'(pt_mem[n]) ^ s[(s[ii] + s[j]) % 256];
    end
    ref_s = s;
  endtask

  task automatic load_str(input int l, input string str);
    pt_mem[0] = 8'(l);
    for (int n = 0; n < str.len(); n++) pt_mem[n+1] = str[n];
  endtask

  task automatic prep();
    ct_pulses = 0;
    ct_oob    = 0;
    cur_len   = int'(pt_mem[0]);
    for (int n = 0; n < 256; n++) ct_mem[n] = 8'hEE;
  endtask

  task automatic start(input logic [23:0] k, input bit hold);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
  endtask

  task automatic wait_done(output int cyc, input int poke, input logic [23:0] alt);
    int bad;
    bit done;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == poke) begin
        key = alt;
        en  = 1'b1;
      end else if (cyc == poke + 1) begin
        en = 1'b0;
      end
      if (cyc == 256) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(n)) bad++;
        check_val("init_identity", bad, 0);
      end
      if (cyc == 1792) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (int'(s_mem[n]) != ref_ksa[n]) bad++;
        check_val("ksa_perm", bad, 0);
      end
      if (rdy) done = 1'b1;
    end
    check_val("run_done", int'(done), 1);
  endtask

  task automatic check_run(input string tag, input int cyc);
    int l, nw, bad;
    l   = cur_len;
    nw  = (l < 1) ? 1 : l;
    check_val({tag, "_latency"}, cyc, (l <= 1) ? 1794 : 1794 + 8 * (l - 1));
    check_val({tag, "_pulses"}, ct_pulses, nw);
    check_val({tag, "_oob"}, ct_oob, 0);
    bad = 0;
    for (int n = 0; n < nw; n++) if (int'(ct_mem[n]) != ref_ct[n]) bad++;
    check_val({tag, "_ct"}, bad, 0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (int'(s_mem[n]) != ref_s[n]) bad++;
    check_val({tag, "_sfinal"}, bad, 0);
  endtask

  task automatic run_full(input string tag, input logic [23:0] k, input int poke,
                          input logic [23:0] alt, output int cyc);
    prep();
    model_run(k);
    start(k, 1'b0);
    wait_done(cyc, poke, alt);
    check_run(tag, cyc);
  endtask

  task automatic check_known(input string tag);
    for (int n = 0; n < 10; n++) check_val($sformatf("%s_byte%0d", tag, n), int'(ct_mem[n]), int'(kv_ct[n]));
  endtask

  initial begin
    int cyc, bad, l;
    logic [23:0] rk;
    byte_t orig[256];

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rdy", int'(rdy), 1);
    check_val("rst_s_wren", int'(s_wren), 0);
    check_val("rst_ct_wren", int'(ct_wren), 0);
    check_val("rst_s_addr", int'(s_addr), 0);
    check_val("rst_s_wrdata", int'(s_wrdata), 0);
    check_val("rst_pt_addr", int'(pt_addr), 0);
    check_val("rst_ct_addr", int'(ct_addr), 0);
    check_val("rst_ct_wrdata", int'(ct_wrdata), 0);
    rst_n = 1'b1;

    // Known vector
    load_str(10, "Plaintext");
    run_full("known", 24'h4B6579, -1, '0, cyc);
    check_known("known");
    check_val("known_rdy", int'(rdy), 1);

    // Round trip: encrypting the ciphertext with the same key restores the plaintext
    load_str(5, "Hi!!");
    for (int n = 0; n < 5; n++) orig[n] = pt_mem[n];
    run_full("rt_enc", 24'h000018, -1, '0, cyc);
    for (int n = 0; n < 5; n++) pt_mem[n] = ct_mem[n];
    run_full("rt_dec", 24'h000018, -1, '0, cyc);
    bad = 0;
    for (int n = 0; n < 5; n++) if (ct_mem[n] !== orig[n]) bad++;
    check_val("rt_roundtrip", bad, 0);

    // Length edges
    pt_mem[0] = 8'd1;
    run_full("len1", 24'h123456, -1, '0, cyc);
    check_val("len1_ct0", int'(ct_mem[0]), 1);
    pt_mem[0] = 8'd0;
    run_full("len0", 24'h000000, -1, '0, cyc);
    check_val("len0_ct0", int'(ct_mem[0]), 0);
    pt_mem[0] = 8'd255;
    for (int n = 1; n < 255; n++) pt_mem[n] = 8'($urandom);
    run_full("len255", 24'($urandom), -1, '0, cyc);
    check_val("len255_bound", int'(cyc <= 256 + 256 * 6 + 255 * 8 + 8), 1);

    // Randomized keys and printable plaintexts
    for (int r = 0; r < 4; r++) begin
      l = int'($urandom_range(40, 2));
      pt_mem[0] = 8'(l);
      for (int n = 1; n < l; n++)
        pt_mem[n] = 8'($urandom_range(32'(PT_PRINTABLE_HI), 32'(PT_PRINTABLE_LO)));
      rk = 24'($urandom);
      run_full($sformatf("rand%0d", r), rk, -1, '0, cyc);
    end

    // en with a different key mid-run is ignored
    load_str(10, "Plaintext");
    run_full("midrun_en", 24'h4B6579, 500, 24'hA5A5A5, cyc);
    check_known("midrun_en");

    // en held high: second identical run starts one cycle after rdy rises
    prep();
    model_run(24'h4B6579);
    start(24'h4B6579, 1'b1);
    wait_done(cyc, -1, '0);
    check_run("hold1", cyc);
    @(posedge clk);
    #1;
    check_val("hold_restart_rdy", int'(rdy), 0);
    en = 1'b0;
    prep();
    wait_done(cyc, -1, '0);
    check_run("hold2", cyc);
    check_known("hold2");

    // Reset during PRGA at k=3, then a clean rerun
    prep();
    model_run(24'h4B6579);
    start(24'h4B6579, 1'b0);
    cyc = 0;
    while (ct_pulses < 3 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("reached_k3", ct_pulses, 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_rdy", int'(rdy), 1);
    check_val("midrst_s_wren", int'(s_wren), 0);
    check_val("midrst_ct_wren", int'(ct_wren), 0);
    rst_n = 1'b1;
    run_full("after_rst", 24'h4B6579, -1, '0, cyc);
    check_known("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
